alu_op_sequencer: RTL and testbench

Front-end controller for the `TotalALU` datapath. It accepts one operation at a time over a valid/ready request channel and pulses the ALU's reset before each operation. It drives `Signal`/`dataA`/`dataB` for the required number of cycles; for MULTU it waits out the multiply and then issues MFHI and MFLO automatically. The result is returned on a valid/ready response channel, so upstream pipeline logic never sequences the ALU directly.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_stats.sv | 19 +
 rtl/alu_op_sequencer.sv | 115 +++++++++++
 tb/tb_alu_op_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared funct codes, FSM state encoding and decode helper for the ALU sequencer.
package alu_seq_pkg;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_EXEC, S_MUL, S_RDHI, S_RDLO, S_RESP
  } state_t;

  // MFHI/MFLO are issued internally after MULTU and are rejected as requests.
  function automatic logic is_supported(input logic [5:0] f);
    return (f == F_AND) || (f == F_OR) || (f == F_ADD) || (f == F_SUB) ||
           (f == F_SLT) || (f == F_SLL) || (f == F_MULTU);
  endfunction
endpackage

// File: rtl/alu_seq_stats.sv
// Optional activity counters for the ALU sequencer: completed responses and busy cycles.
module alu_seq_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        rsp_fire,
  input  logic        busy,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_busy
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops  <= '0;
      stat_busy <= '0;
    end else begin
      if (rsp_fire) stat_ops <= stat_ops + 32'd1;
      if (busy)     stat_busy <= stat_busy + 32'd1;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response front-end that sequences the TotalALU: clear, execute (or multiply
// then MFHI/MFLO), respond. Define ALU_SEQ_STATS_EN to add the stat_ops/stat_busy counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int MUL_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic        alu_reset,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_out
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_busy
`endif
);
  localparam int MAXC = (EXEC_CYCLES > MUL_CYCLES) ? EXEC_CYCLES : MUL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t          state, state_n;
  logic [5:0]      funct_q;
  logic [CW-1:0]   cnt;

  always_comb begin
    state_n    = state;
    alu_signal = 6'd0;
    unique case (state)
      S_IDLE: if (req_valid) state_n = is_supported(req_funct) ? S_CLR : S_RESP;
      S_CLR:  state_n = (funct_q == F_MULTU) ? S_MUL : S_EXEC;
      S_EXEC: begin
        alu_signal = funct_q;
        if (cnt == '0) state_n = S_RESP;
      end
      S_MUL: begin
        alu_signal = F_MULTU;
        if (cnt == '0) state_n = S_RDHI;
      end
      S_RDHI: begin
        alu_signal = F_MFHI;
        state_n    = S_RDLO;
      end
      S_RDLO: begin
        alu_signal = F_MFLO;
        state_n    = S_RESP;
      end
      S_RESP: if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE) && !reset;
  assign rsp_valid = (state == S_RESP);
  assign alu_reset = reset || (state == S_CLR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      funct_q   <= '0;
      cnt       <= '0;
      alu_dataA <= '0;
      alu_dataB <= '0;
      rsp_data  <= '0;
      rsp_hi    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: if (req_valid) begin
          funct_q  <= req_funct;
          rsp_data <= '0;
          rsp_hi   <= '0;
          rsp_err  <= !is_supported(req_funct);
          // Rejected requests leave the ALU operand bus untouched.
          if (is_supported(req_funct)) begin
            alu_dataA <= req_a;
            alu_dataB <= req_b;
          end
        end
        S_CLR:  cnt <= (funct_q == F_MULTU) ? CW'(MUL_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
        S_EXEC: if (cnt == '0) rsp_data <= alu_out;
                else           cnt <= cnt - 1'b1;
        S_MUL:  if (cnt != '0) cnt <= cnt - 1'b1;
        S_RDHI: rsp_hi   <= alu_out;
        S_RDLO: rsp_data <= alu_out;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats u_stats (
    .clk       (clk),
    .reset     (reset),
    .rsp_fire  (rsp_valid && rsp_ready),
    .busy      (state != S_IDLE),
    .stat_ops  (stat_ops),
    .stat_busy (stat_busy)
  );
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural TotalALU stand-in and a response scoreboard.
module tb_alu_op_sequencer;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, rsp_err, alu_reset;
  logic [5:0]  req_funct = 0, alu_signal;
  logic [31:0] req_a = 0, req_b = 0, rsp_data, rsp_hi, alu_dataA, alu_dataB, alu_out;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_ops, stat_busy;
`endif

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
    .alu_reset(alu_reset), .alu_signal(alu_signal), .alu_dataA(alu_dataA),
    .alu_dataB(alu_dataB), .alu_out(alu_out)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_busy(stat_busy)
`endif
  );

  always #5 clk = ~clk;

  // TotalALU stand-in: product appears only after 33 consecutive MULTU cycles.
  logic [31:0] m_hi, m_lo;
  int          m_cnt;
  always @(posedge clk or posedge alu_reset) begin
    if (alu_reset) begin
      m_hi <= 0; m_lo <= 0; m_cnt <= 0;
    end else if (alu_signal == 6'd25) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 32) {m_hi, m_lo} <= {32'd0, alu_dataA} * {32'd0, alu_dataB};
    end
  end
  always_comb begin
    alu_out = 32'd0;
    case (alu_signal)
      6'd36: alu_out = alu_dataA & alu_dataB;
      6'd37: alu_out = alu_dataA | alu_dataB;
      6'd32: alu_out = alu_dataA + alu_dataB;
      6'd34: alu_out = alu_dataA - alu_dataB;
      6'd42: alu_out = {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
      6'd0:  alu_out = alu_dataA << alu_dataB[4:0];
      6'd16: alu_out = m_hi;
      6'd18: alu_out = m_lo;
      default: alu_out = 32'd0;
    endcase
  end

  typedef struct { logic [31:0] d; logic [31:0] h; logic e; } rsp_t;
  typedef struct { logic [5:0] f; logic [31:0] a; logic [31:0] b; rsp_t r; int lat; } vec_t;

  int   n_cmp = 0, n_bad = 0;
  rsp_t sb[$];
  logic [5:0] sig_log[$];
  int   rst_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_hi", rsp_hi, e.h);
        chk("rsp_err", rsp_err, e.e);
      end
    end
  end

  // Drive one request, push its expected response, and measure cycles until rsp_valid.
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input rsp_t e, output int lat);
    int k;
    sig_log.delete(); rst_log.delete();
    @(posedge clk); #1;
    req_valid = 1; req_funct = f; req_a = a; req_b = b;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready && k < 100);
    chk("req_ready_timeout", req_ready, 1);
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      sig_log.push_back(alu_signal);
      if (alu_reset) rst_log.push_back(n);
      if (rsp_valid) begin lat = n; break; end
    end
    chk("rsp_timeout", lat != 0, 1);
  endtask

  vec_t vt[13];
  initial begin
    int lat, cnt25, cnt_v;
    vt[0]  = '{6'd32, 32'd5, 32'd7, '{32'd12, 0, 0}, 3};
    vt[1]  = '{6'd36, 32'hF0, 32'h3C, '{32'h30, 0, 0}, 3};
    vt[2]  = '{6'd37, 32'hF0, 32'h0F, '{32'hFF, 0, 0}, 3};
    vt[3]  = '{6'd34, 32'd5, 32'd7, '{32'hFFFFFFFE, 0, 0}, 3};
    vt[4]  = '{6'd42, 32'hFFFFFFFF, 32'd1, '{32'd1, 0, 0}, 3};
    vt[5]  = '{6'd42, 32'd1, 32'hFFFFFFFF, '{32'd0, 0, 0}, 3};
    vt[6]  = '{6'd0, 32'd1, 32'd4, '{32'h10, 0, 0}, 3};
    vt[7]  = '{6'd25, 32'hFFFFFFFF, 32'd2, '{32'hFFFFFFFE, 32'd1, 0}, 37};
    vt[8]  = '{6'd25, 32'h12345678, 32'h10, '{32'h23456780, 32'd1, 0}, 37};
    vt[9]  = '{6'd99 & 6'h3F, 32'd1, 32'd2, '{32'd0, 0, 1}, 1};
    vt[10] = '{6'd16, 32'd1, 32'd2, '{32'd0, 0, 1}, 1};
    vt[11] = '{6'd18, 32'd1, 32'd2, '{32'd0, 0, 1}, 1};
    vt[12] = '{6'd63, 32'd1, 32'd2, '{32'd0, 0, 1}, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_hi", rsp_hi, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_signal", alu_signal, 0);
    chk("rst_dataA", alu_dataA, 0);
    chk("rst_dataB", alu_dataB, 0);
    chk("rst_alu_reset", alu_reset, 1);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_alu_reset", alu_reset, 0);

    // ADD: clear pulse in cycle 1 only, response in cycle 3
    send(6'd32, 32'd5, 32'd7, '{32'd12, 0, 0}, lat);
    chk("add_lat", lat, 3);
    chk("add_rst_pulses", rst_log.size(), 1);
    if (rst_log.size() > 0) chk("add_rst_cycle", rst_log[0], 1);

    // MULTU: 25 x33 in cycles 2..34, then 16, 18
    send(6'd25, 32'hFFFFFFFF, 32'd2, '{32'hFFFFFFFE, 32'd1, 0}, lat);
    chk("mul_lat", lat, 37);
    cnt25 = 0;
    foreach (sig_log[i]) if (i >= 1 && i <= 33 && sig_log[i] == 6'd25) cnt25++;
    chk("mul_25_count", cnt25, 33);
    if (sig_log.size() >= 36) begin
      chk("mul_clr_sig", sig_log[0], 0);
      chk("mul_rdhi_sig", sig_log[34], 16);
      chk("mul_rdlo_sig", sig_log[35], 18);
    end else chk("mul_sig_len", sig_log.size(), 37);

    // Unsupported funct: immediate error, ALU untouched
    send(6'd35 + 6'd0 + 6'd28 + 6'd36, 32'd9, 32'd9, '{32'd0, 0, 1}, lat);
    chk("err_lat", lat, 1);
    chk("err_no_alu_reset", rst_log.size(), 0);
    chk("err_sig", sig_log[0], 0);
    chk("err_dataA_kept", alu_dataA, 32'hFFFFFFFF);
    @(posedge clk); #1;
`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops", stat_ops, 3);
    chk("stat_busy", stat_busy, 41);
`endif

    // SLT with a response stall, SLL waiting behind it
    rsp_ready = 0;
    send(6'd42, 32'hFFFFFFFF, 32'd1, '{32'd1, 0, 0}, lat);
    chk("slt_lat", lat, 3);
    @(posedge clk); #1;
    req_valid = 1; req_funct = 6'd0; req_a = 32'd3; req_b = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", rsp_data, 1);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    chk("fire_req_ready", req_ready, 0);
    @(negedge clk);
    chk("after_fire_req_ready", req_ready, 1);
    sb.push_back('{32'd12, 0, 0});
    @(posedge clk); #1 req_valid = 0;
    cnt_v = 0;
    for (int n = 0; n < 20 && !rsp_valid; n++) begin @(negedge clk); cnt_v++; end
    chk("sll_lat", cnt_v, 3);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // Reset in cycle 10 of a MULTU: abort, no response
    @(posedge clk); #1;
    req_valid = 1; req_funct = 6'd25; req_a = 32'd7; req_b = 32'd9;
    @(negedge clk);
    chk("mul2_req_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 0;
    repeat (10) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_signal", alu_signal, 0);
    chk("abort_dataA", alu_dataA, 0);
    chk("abort_alu_reset", alu_reset, 1);
    chk("abort_req_ready", req_ready, 0);
    @(posedge clk); #1 reset = 0;
    cnt_v = 0;
    for (int n = 0; n < 40; n++) begin @(negedge clk); if (rsp_valid) cnt_v++; end
    chk("abort_no_rsp", cnt_v, 0);
    send(6'd36, 32'hF0, 32'h3C, '{32'h30, 0, 0}, lat);
    chk("and_after_abort_lat", lat, 3);

    // Table of vectors
    foreach (vt[i]) begin
      send(vt[i].f, vt[i].a, vt[i].b, vt[i].r, lat);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end
    @(posedge clk); @(negedge clk);
    chk("sb_final", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
